// File: rtl/ghr_index_unit_pkg.sv
// Shared widths, opcode constant and checkpoint entry type for the global-history index unit.
package ghr_index_unit_pkg;

    localparam int PT_IDX_W = 12;
    localparam int GHR_W = 12;
    localparam logic [6:0] BR_OPCODE = 7'b1100011;

    typedef struct packed {
        logic [PT_IDX_W-1:0] idx;
        logic [GHR_W-1:0]    hist;
    } ghr_ckpt_t;

endpackage

// File: rtl/ghr_ckpt_fifo.sv
// In-flight branch checkpoint FIFO: DEPTH entries, flush, registered head entry.
module ghr_ckpt_fifo
    import ghr_index_unit_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      push,
    input  logic      pop,
    input  logic      flush,
    input  ghr_ckpt_t din,
    output ghr_ckpt_t head,
    output logic      head_valid,
    output logic      full
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    ghr_ckpt_t        mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_next;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_next;
    logic             push_ok;
    logic             pop_ok;

    assign head_valid = (count != '0);
    assign full       = (count == CNT_W'(DEPTH));
    assign push_ok    = push & ~full & ~flush;
    assign pop_ok     = pop & head_valid;

    always_comb begin
        rd_next    = pop_ok ? rd_ptr + PTR_W'(1) : rd_ptr;
        count_next = count;
        if (push_ok && !pop_ok)
            count_next = count + CNT_W'(1);
        else if (pop_ok && !push_ok)
            count_next = count - CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (push_ok)
            mem[wr_ptr] <= din;
    end

    // Head is re-registered every cycle; a push into the slot becoming head bypasses the array.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            head   <= '0;
        end else if (flush) begin
            rd_ptr <= wr_ptr;
            count  <= '0;
            head   <= '0;
        end else begin
            if (push_ok)
                wr_ptr <= wr_ptr + PTR_W'(1);
            rd_ptr <= rd_next;
            count  <= count_next;
            if (count_next == '0)
                head <= '0;
            else if (push_ok && (rd_next == wr_ptr))
                head <= din;
            else
                head <= mem[rd_next];
        end
    end

endmodule

// File: rtl/ghr_index_unit.sv
// Global history tracking, pattern-table index generation and mispredict repair.
// GSHARE_HASH_EN: hash history into addr (gshare); undefined gives bimodal indexing.
module ghr_index_unit
    import ghr_index_unit_pkg::*;
#(
    parameter int IDX_W = PT_IDX_W,
    parameter int HIST_W = GHR_W,
    parameter int DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       fetch_pc,
    input  logic              fetch_valid,
    input  logic              fetch_is_branch,
    input  logic              predict,
    output logic [IDX_W-1:0]  addr,
    input  logic              resolve_valid,
    input  logic              resolve_taken,
    input  logic              resolve_mispredict,
    output logic [IDX_W-1:0]  past,
    output logic              past_valid,
    output logic              full,
    output logic [HIST_W-1:0] arch_hist,
    output logic              err_underflow
);

    logic [HIST_W-1:0] spec_hist;
    ghr_ckpt_t         ckpt_in;
    ghr_ckpt_t         ckpt_head;
    logic              push;
    logic              pop;
    logic              flush;
    logic              unused_pc;

    `ifdef GSHARE_HASH_EN
    assign addr = fetch_pc[IDX_W+1:2] ^ IDX_W'(spec_hist);
    `else
    assign addr = fetch_pc[IDX_W+1:2];
    `endif

    assign unused_pc = ^{fetch_pc[31:IDX_W+2], fetch_pc[1:0]};

    // A fetch in the same cycle as a mispredict is on the wrong path and is dropped.
    assign push  = fetch_valid & fetch_is_branch & ~full & ~(resolve_valid & resolve_mispredict);
    assign pop   = resolve_valid & past_valid;
    assign flush = pop & resolve_mispredict;

    assign ckpt_in.idx  = addr;
    assign ckpt_in.hist = spec_hist;
    assign past         = ckpt_head.idx;

    ghr_ckpt_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push       (push),
        .pop        (pop),
        .flush      (flush),
        .din        (ckpt_in),
        .head       (ckpt_head),
        .head_valid (past_valid),
        .full       (full)
    );

    // Repair rebuilds speculative history from the mispredicted branch's checkpoint.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            spec_hist     <= '0;
            arch_hist     <= '0;
            err_underflow <= 1'b0;
        end else begin
            if (flush)
                spec_hist <= {ckpt_head.hist[HIST_W-2:0], resolve_taken};
            else if (push)
                spec_hist <= {spec_hist[HIST_W-2:0], predict};
            if (pop)
                arch_hist <= {arch_hist[HIST_W-2:0], resolve_taken};
            if (resolve_valid && !past_valid)
                err_underflow <= 1'b1;
        end
    end

endmodule

// File: tb/tb_ghr_index_unit.sv
// Directed self-checking bench for ghr_index_unit (either GSHARE_HASH_EN build).
module tb_ghr_index_unit;
    import ghr_index_unit_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] fetch_pc = '0;
    logic        fetch_valid = 1'b0;
    logic        fetch_is_branch = 1'b0;
    logic        predict = 1'b0;
    logic [11:0] addr;
    logic        resolve_valid = 1'b0;
    logic        resolve_taken = 1'b0;
    logic        resolve_mispredict = 1'b0;
    logic [11:0] past;
    logic        past_valid;
    logic        full;
    logic [11:0] arch_hist;
    logic        err_underflow;

    int checks = 0;
    int failures = 0;

    ghr_index_unit dut (
        .clk                (clk),
        .rst                (rst),
        .fetch_pc           (fetch_pc),
        .fetch_valid        (fetch_valid),
        .fetch_is_branch    (fetch_is_branch),
        .predict            (predict),
        .addr               (addr),
        .resolve_valid      (resolve_valid),
        .resolve_taken      (resolve_taken),
        .resolve_mispredict (resolve_mispredict),
        .past               (past),
        .past_valid         (past_valid),
        .full               (full),
        .arch_hist          (arch_hist),
        .err_underflow      (err_underflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [11:0] ex_addr(input logic [31:0] pc, input logic [11:0] h);
        logic [11:0] m;
        m = h;
        `ifndef GSHARE_HASH_EN
        m = '0;
        `endif
        return pc[13:2] ^ m;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        fetch_valid = 1'b0;
        fetch_is_branch = 1'b0;
        predict = 1'b0;
        resolve_valid = 1'b0;
        resolve_taken = 1'b0;
        resolve_mispredict = 1'b0;
    endtask

    task automatic fetch(input logic [31:0] pc, input logic p);
        fetch_pc = pc;
        fetch_valid = 1'b1;
        fetch_is_branch = 1'b1;
        predict = p;
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        #1;
        rst = 1'b0;
    endtask

    initial begin
        logic [11:0] pattern;

        // Reset state
        idle();
        fetch_pc = 32'h0000_0040;
        #3;
        chk("rst_past", past, 12'h000);
        chk("rst_past_valid", past_valid, 1'b0);
        chk("rst_full", full, 1'b0);
        chk("rst_arch", arch_hist, 12'h000);
        chk("rst_err", err_underflow, 1'b0);
        chk("rst_addr", addr, 12'h010);
        rst = 1'b0;
        step();

        // First branch
        fetch(32'h0000_0040, 1'b1);
        chk("t1_addr", addr, 12'h010);
        step();
        idle();
        chk("t1_past", past, 12'h010);
        chk("t1_past_valid", past_valid, 1'b1);
        chk("t1_spec", dut.spec_hist, 12'h001);

        // Fill to full, fifth branch refused, then one resolve
        pulse_reset();
        step();
        fetch(32'h0000_0100, 1'b1); step();
        fetch(32'h0000_0104, 1'b0); step();
        fetch(32'h0000_0108, 1'b1); step();
        fetch(32'h0000_010C, 1'b1); step();
        chk("t2_full", full, 1'b1);
        chk("t2_spec4", dut.spec_hist, 12'h00B);
        fetch(32'h0000_0110, 1'b1); step();
        idle();
        chk("t2_spec_nopush", dut.spec_hist, 12'h00B);
        chk("t2_count", dut.u_fifo.count, 3'd4);
        chk("t2_head", past, ex_addr(32'h0000_0100, 12'h000));
        resolve_valid = 1'b1; resolve_taken = 1'b1; step();
        idle();
        chk("t2_full_after", full, 1'b0);
        chk("t2_arch", arch_hist, 12'h001);
        chk("t2_past2", past, ex_addr(32'h0000_0104, 12'h001));

        // Mispredict repair with a same-cycle push dropped
        pulse_reset();
        step();
        fetch(32'h0000_0200, 1'b1); step();
        fetch(32'h0000_0204, 1'b0); step();
        chk("t3_spec_pre", dut.spec_hist, 12'h002);
        fetch(32'h0000_0208, 1'b1);
        resolve_valid = 1'b1; resolve_taken = 1'b0; resolve_mispredict = 1'b1;
        step();
        idle();
        chk("t3_spec", dut.spec_hist, 12'h000);
        chk("t3_past_valid", past_valid, 1'b0);
        chk("t3_count", dut.u_fifo.count, 3'd0);
        chk("t3_arch", arch_hist, 12'h000);

        // Simultaneous push and pop at count 2
        fetch(32'h0000_0300, 1'b0); step();
        fetch(32'h0000_0304, 1'b1); step();
        chk("t4_count2", dut.u_fifo.count, 3'd2);
        chk("t4_head0", past, ex_addr(32'h0000_0300, 12'h000));
        fetch(32'h0000_0308, 1'b0);
        resolve_valid = 1'b1; resolve_taken = 1'b1;
        step();
        idle();
        chk("t4_count_same", dut.u_fifo.count, 3'd2);
        chk("t4_head1", past, ex_addr(32'h0000_0304, 12'h000));
        chk("t4_arch1", arch_hist, 12'h001);
        chk("t4_spec", dut.spec_hist, 12'h002);
        resolve_valid = 1'b1; resolve_taken = 1'b0; step();
        idle();
        chk("t4_head2", past, ex_addr(32'h0000_0308, 12'h001));
        chk("t4_count1", dut.u_fifo.count, 3'd1);
        resolve_valid = 1'b1; resolve_taken = 1'b1; step();
        idle();
        chk("t4_empty", past_valid, 1'b0);
        chk("t4_arch3", arch_hist, 12'h005);

        // Underflow and asynchronous mid-stream reset
        resolve_valid = 1'b1; resolve_taken = 1'b1; step();
        idle();
        chk("t5_err", err_underflow, 1'b1);
        chk("t5_arch_hold", arch_hist, 12'h005);
        fetch(32'h0000_0400, 1'b1); step();
        idle();
        chk("t5_err_sticky", err_underflow, 1'b1);
        chk("t5_pv_pre", past_valid, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        chk("t5_rst_err", err_underflow, 1'b0);
        chk("t5_rst_arch", arch_hist, 12'h000);
        chk("t5_rst_pv", past_valid, 1'b0);
        chk("t5_rst_past", past, 12'h000);
        chk("t5_rst_full", full, 1'b0);
        chk("t5_rst_spec", dut.spec_hist, 12'h000);
        rst = 1'b0;
        step();

        // Build spec_hist = 0xABC, then index pc 0x1000
        pattern = 12'hABC;
        for (int i = 11; i >= 0; i--) begin
            fetch(32'h0000_0500, pattern[i]);
            resolve_valid = (i != 11);
            resolve_taken = 1'b0;
            step();
        end
        idle();
        fetch_pc = 32'h0000_1000;
        #1;
        chk("t6_spec", dut.spec_hist, 12'hABC);
        `ifdef GSHARE_HASH_EN
        chk("t6_addr", addr, 12'hEBC);
        `else
        chk("t6_addr", addr, 12'h400);
        `endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ghr_index_unit.md
Name: ghr_index_unit

Overview:
- Sits directly upstream of the 4096-entry 2-bit pattern table (gshare-style predictor).
- Keeps the speculative and architectural global branch history.
- Produces the fetch-time table index `addr` and the resolve-time index `past`.
- Holds each in-flight branch's index and history checkpoint in a small FIFO so that the resolving branch updates the entry it predicted from, and history is repaired on a mispredict.

Parameters:
- IDX_W, 12, pattern-table index width (addr/past width).
- HIST_W, 12, global history length in bits (HIST_W <= IDX_W).
- DEPTH, 4, in-flight branch FIFO entries (power of two, >= 2).

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  asynchronous active-high reset.
- fetch_pc  in  32  PC of the instruction in fetch.
- fetch_valid  in  1  fetch slot holds a valid instruction.
- fetch_is_branch  in  1  fetch instruction is a conditional branch (opcode 1100011).
- predict  in  1  direction prediction returned by the pattern table for `addr`.
- addr  out  IDX_W  pattern-table lookup index for the fetch instruction.
- resolve_valid  in  1  oldest in-flight branch resolves this cycle.
- resolve_taken  in  1  actual direction of the resolving branch.
- resolve_mispredict  in  1  resolving branch was mispredicted (qualified by resolve_valid).
- past  out  IDX_W  index of the oldest in-flight branch (pattern-table update index).
- past_valid  out  1  FIFO not empty; `past` is meaningful.
- full  out  1  FIFO holds DEPTH entries; fetch must stall branches.
- arch_hist  out  HIST_W  committed global history (debug/verification).
- err_underflow  out  1  sticky: resolve_valid seen while FIFO empty.

Behaviour:
- Reset (async, rst=1): spec_hist=0, arch_hist=0, FIFO empty (count=0, rd/wr ptr=0), err_underflow=0. Hence addr=hashed fetch_pc with zero history, past=0, past_valid=0, full=0.
- addr is combinational: fetch_pc[IDX_W+1:2] XOR zero-extended spec_hist. Zero latency, so the table lookup happens in the same cycle.
- Push when fetch_valid & fetch_is_branch & !full & !(resolve_valid & resolve_mispredict):
  - write {addr, spec_hist} at wr_ptr;
  - spec_hist <= {spec_hist[HIST_W-2:0], predict}.
- A branch is not pushed when full=1. The fetch stage is required to stall; the unit does not stall fetch itself. spec_hist is unchanged.
- past and past_valid are driven from the registered head entry. They change only at posedge, so they are stable for the whole cycle, including the table's negedge update.
- Pop when resolve_valid & past_valid:
  - arch_hist <= {arch_hist[HIST_W-2:0], resolve_taken};
  - rd_ptr advances.
- Mispredict (pop with resolve_mispredict=1):
  - spec_hist <= {head.hist[HIST_W-2:0], resolve_taken};
  - all FIFO entries are discarded (count=0, rd_ptr=wr_ptr);
  - a push in the same cycle is dropped, because the younger fetch is on the wrong path.
- Push and non-mispredict pop in the same cycle: both take effect and count is unchanged. full is based on the current count, so a push is refused while full even if a pop occurs that cycle.
- resolve_valid while empty: no state change except err_underflow <= 1, which holds until reset.
- Pointers wrap modulo DEPTH. The count register is width clog2(DEPTH)+1.
- Reset mid-operation aborts all in-flight entries immediately.

Optional Feature:
- GSHARE_HASH_EN defined: addr = PC bits XOR spec_hist (gshare).
- GSHARE_HASH_EN undefined: addr = fetch_pc[IDX_W+1:2] only (bimodal). History registers, FIFO and repair logic are unchanged and arch_hist is still maintained.
- past always returns the stored index in both modes.

Decomposition:
- Shared package holds:
  - PT_IDX_W=12, GHR_W=12 and BR_OPCODE=7'b1100011;
  - typedef of the FIFO entry struct {idx, hist}.
- One sub-module, ghr_ckpt_fifo: a synchronous FIFO with DEPTH entries, a flush input and a registered head output.
- History shift, index hashing and repair logic stay in ghr_index_unit.

Test Plan:
- Reset then fetch branch at pc=0x0000_0040, predict=1 -> addr=0x010, next cycle past=0x010, past_valid=1, spec_hist=0x001.
- Four branches pushed with predict=1,0,1,1 and no resolves -> full=1 and a fifth branch is not pushed. Then resolve one taken, non-mispredict -> full=0, arch_hist=0x001, past=2nd entry's index.
- Push two branches (hist checkpoints 0x000, 0x001), then resolve the first with taken=0, mispredict=1 -> spec_hist=0x000, FIFO empty, past_valid=0, and a same-cycle push is dropped.
- Simultaneous push and non-mispredict pop at count=2 -> count stays 2 and the head advances in order.
- resolve_valid at count=0 -> err_underflow=1, arch_hist unchanged; then assert rst mid-stream -> all outputs return to reset values asynchronously.
- Build without GSHARE_HASH_EN, spec_hist=0xABC, pc=0x0000_1000 -> addr=0x400. Build with it -> addr=0x400^0xABC=0xEBC.
